// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the multi-port register file.
// Optional macro REGFILE_BYPASS_EN is consumed by regfile_mp.
package regfile_pkg;

  // Default configuration (classic 32 x 32-bit file with r31 hardwired to 0)
  localparam int REGFILE_DATA_W   = 32;
  localparam int REGFILE_ADDR_W   = 5;
  localparam int REGFILE_N_READ   = 2;
  localparam int REGFILE_ZERO_REG = 31;

  // Widest slice and widest packed port vector the helper can handle:
  // up to 4 ports of up to 64 bits each.
  localparam int SLICE_MAX_W = 64;
  localparam int VEC_MAX_W   = 256;

  // Return slice k of width w from a packed per-port vector, zero-extended.
  function automatic logic [SLICE_MAX_W-1:0] port_slice(
    input logic [VEC_MAX_W-1:0] vec,
    input int                   k,
    input int                   w
  );
    logic [SLICE_MAX_W-1:0] mask;
    mask = (SLICE_MAX_W'(1) << w) - SLICE_MAX_W'(1);
    return SLICE_MAX_W'(vec >> (k * w)) & mask;
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register pending-write scoreboard: issue sets, writeback clears,
// a simultaneous set and clear on the same register leaves it set, and the
// hardwired-zero register can never be marked busy.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int ADDR_W   = REGFILE_ADDR_W,
  parameter int ZERO_REG = REGFILE_ZERO_REG
)(
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     set_en_i,
  input  logic [ADDR_W-1:0]        set_add_i,
  input  logic                     clr_en_i,
  input  logic [ADDR_W-1:0]        clr_add_i,
  output logic [(2**ADDR_W)-1:0]   busy_vec_o
);

  localparam int                DEPTH     = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_REG);

  logic [DEPTH-1:0] busy_d;
  logic [DEPTH-1:0] busy_q;

  // Next-state: clear first, then set, so a new producer overrides the old one.
  always_comb begin
    // NOTE: assigning a default first on every path keeps this block free of inferred latches.
    busy_d = busy_q;
    if (clr_en_i) busy_d[clr_add_i] = 1'b0;
    if (set_en_i) busy_d[set_add_i] = 1'b1;
    busy_d[ZERO_ADDR] = 1'b0;
  end

  // Busy-bit register with asynchronous reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    // NOTE: non-blocking assignments here so every flop samples pre-edge values.
    if (rst_i) busy_q <= '0;
    else       busy_q <= busy_d;
  end

  assign busy_vec_o = busy_q;

endmodule

// File: rtl/regfile_mp.sv
// Parametrised N-read / 1-write register file with hardwired-zero register,
// pending-write scoreboard and optional write-to-read bypass.
// Define REGFILE_BYPASS_EN to forward writeback data to same-cycle readers.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W   = REGFILE_DATA_W,
  parameter int ADDR_W   = REGFILE_ADDR_W,
  parameter int N_READ   = REGFILE_N_READ,
  parameter int ZERO_REG = REGFILE_ZERO_REG
)(
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       write_en_i,
  input  logic [ADDR_W-1:0]          w_add_i,
  input  logic [DATA_W-1:0]          w_dat_i,
  input  logic                       sb_set_en_i,
  input  logic [ADDR_W-1:0]          sb_set_add_i,
  input  logic [N_READ*ADDR_W-1:0]   rd_add_i,
  output logic [N_READ*DATA_W-1:0]   rd_dat_o,
  output logic [N_READ-1:0]          rd_busy_o,
  output logic [(2**ADDR_W)-1:0]     busy_vec_o
);

  localparam int                DEPTH     = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_REG);

  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [ADDR_W-1:0] rd_addr [N_READ];
  logic [N_READ-1:0] bypass_hit;

  // Pending-write tracking; writeback releases the reservation it completes.
  regfile_scoreboard #(
    .ADDR_W   (ADDR_W),
    .ZERO_REG (ZERO_REG)
  ) u_scoreboard (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .set_en_i   (sb_set_en_i),
    .set_add_i  (sb_set_add_i),
    .clr_en_i   (write_en_i),
    .clr_add_i  (w_add_i),
    .busy_vec_o (busy_vec_o)
  );

  // Storage next-state: writes to the hardwired-zero register are dropped.
  always_comb begin
    mem_d = mem_q;
    if (write_en_i && (w_add_i != ZERO_ADDR)) mem_d[w_add_i] = w_dat_i;
  end

  // Storage flops.
  always_ff @(posedge clk_i or posedge rst_i) begin
    // NOTE: the array is reset on purpose: the register file must read 0 after reset, so it maps to flops, not RAM.
    if (rst_i) mem_q <= '{default: '0};
    else       mem_q <= mem_d;
  end

  // Unpack per-port read addresses.
  always_comb begin
    for (int k = 0; k < N_READ; k++) begin
      rd_addr[k] = ADDR_W'(port_slice(VEC_MAX_W'(rd_add_i), k, ADDR_W));
    end
  end

  // Per-port bypass detect: a same-cycle writeback to the port's register.
  always_comb begin
    bypass_hit = '0;
    for (int k = 0; k < N_READ; k++) begin
`ifdef REGFILE_BYPASS_EN
      bypass_hit[k] = write_en_i && (w_add_i == rd_addr[k]) && (rd_addr[k] != ZERO_ADDR);
`else
      bypass_hit[k] = 1'b0;
`endif
    end
  end

  // Read muxes: zero register, then bypass, then stored value and busy bit.
  always_comb begin
    rd_dat_o  = '0;
    rd_busy_o = '0;
    for (int k = 0; k < N_READ; k++) begin
      if (rd_addr[k] == ZERO_ADDR) begin
        rd_dat_o[k*DATA_W +: DATA_W] = '0;
        rd_busy_o[k]                 = 1'b0;
      end else if (bypass_hit[k]) begin
        // A new reservation issued this same cycle still wins over the release.
        rd_dat_o[k*DATA_W +: DATA_W] = w_dat_i;
        rd_busy_o[k]                 = sb_set_en_i && (sb_set_add_i == rd_addr[k]);
      end else begin
        rd_dat_o[k*DATA_W +: DATA_W] = mem_q[rd_addr[k]];
        rd_busy_o[k]                 = busy_vec_o[rd_addr[k]];
      end
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: default 32x32/2-port instance plus a
// 16-bit, 8-entry, 4-port instance with the zero register at index 0.
module tb_regfile_mp;

  logic clk_i = 1'b0;
  logic rst_i = 1'b0;

  always #5 clk_i = ~clk_i;

  // Default configuration DUT
  logic        write_en_i;
  logic [4:0]  w_add_i;
  logic [31:0] w_dat_i;
  logic        sb_set_en_i;
  logic [4:0]  sb_set_add_i;
  logic [9:0]  rd_add_i;
  logic [63:0] rd_dat_o;
  logic [1:0]  rd_busy_o;
  logic [31:0] busy_vec_o;

  // Swept configuration DUT
  logic        s_write_en;
  logic [2:0]  s_w_add;
  logic [15:0] s_w_dat;
  logic        s_sb_set_en;
  logic [2:0]  s_sb_set_add;
  logic [11:0] s_rd_add;
  logic [63:0] s_rd_dat;
  logic [3:0]  s_rd_busy;
  logic [7:0]  s_busy_vec;

  int vectors     = 0;
  int miscompares = 0;

  regfile_mp dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .write_en_i   (write_en_i),
    .w_add_i      (w_add_i),
    .w_dat_i      (w_dat_i),
    .sb_set_en_i  (sb_set_en_i),
    .sb_set_add_i (sb_set_add_i),
    .rd_add_i     (rd_add_i),
    .rd_dat_o     (rd_dat_o),
    .rd_busy_o    (rd_busy_o),
    .busy_vec_o   (busy_vec_o)
  );

  regfile_mp #(
    .DATA_W   (16),
    .ADDR_W   (3),
    .N_READ   (4),
    .ZERO_REG (0)
  ) dut_s (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .write_en_i   (s_write_en),
    .w_add_i      (s_w_add),
    .w_dat_i      (s_w_dat),
    .sb_set_en_i  (s_sb_set_en),
    .sb_set_add_i (s_sb_set_add),
    .rd_add_i     (s_rd_add),
    .rd_dat_o     (s_rd_dat),
    .rd_busy_o    (s_rd_busy),
    .busy_vec_o   (s_busy_vec)
  );

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    write_en_i = 1'b0; w_add_i = '0; w_dat_i = '0;
    sb_set_en_i = 1'b0; sb_set_add_i = '0; rd_add_i = '0;
    s_write_en = 1'b0; s_w_add = '0; s_w_dat = '0;
    s_sb_set_en = 1'b0; s_sb_set_add = '0; s_rd_add = '0;

    // Power-on reset
    #1 rst_i = 1'b1;
    rd_add_i = {5'd3, 5'd1};
    #2;
    check("por_rd_dat",   rd_dat_o,   64'h0);
    check("por_busy_vec", busy_vec_o, 64'h0);
    check("por_rd_busy",  rd_busy_o,  64'h0);
    tick();
    rst_i = 1'b0;

    // 1: write r3, reserve r4, then asynchronous reset mid-cycle
    write_en_i = 1'b1; w_add_i = 5'd3; w_dat_i = 32'hDEADBEEF;
    sb_set_en_i = 1'b1; sb_set_add_i = 5'd4;
    tick();
    write_en_i = 1'b0; sb_set_en_i = 1'b0;
    rd_add_i = {5'd3, 5'd3};
    #1;
    check("r3_written",   rd_dat_o,   64'hDEADBEEF_DEADBEEF);
    check("r4_reserved",  busy_vec_o, 64'h0000_0010);
    #1 rst_i = 1'b1;
    #1;
    check("async_rst_dat",  rd_dat_o,   64'h0);
    check("async_rst_busy", busy_vec_o, 64'h0);
    rst_i = 1'b0;
    #1;
    check("post_rst_dat", rd_dat_o, 64'h0);
    tick();

    // 2: plain write then read on both ports
    write_en_i = 1'b1; w_add_i = 5'd5; w_dat_i = 32'h12345678;
    tick();
    write_en_i = 1'b0;
    rd_add_i = {5'd5, 5'd5};
    #1;
    check("r5_dat",  rd_dat_o,  64'h12345678_12345678);
    check("r5_busy", rd_busy_o, 64'h0);

    // 3: zero register ignores writes and reservations
    write_en_i = 1'b1; w_add_i = 5'd31; w_dat_i = 32'hFFFFFFFF;
    sb_set_en_i = 1'b1; sb_set_add_i = 5'd31;
    rd_add_i = {5'd31, 5'd31};
    #1;
    check("r31_wcycle_dat", rd_dat_o, 64'h0);
    tick();
    write_en_i = 1'b0; sb_set_en_i = 1'b0;
    #1;
    check("r31_dat",      rd_dat_o,   64'h0);
    check("r31_busy_vec", busy_vec_o, 64'h0);
    check("r31_rd_busy",  rd_busy_o,  64'h0);

    // 4: reserve r7 (cycle 0), observe busy (cycle 1), write at cycle 3
    sb_set_en_i = 1'b1; sb_set_add_i = 5'd7;
    tick();
    sb_set_en_i = 1'b0;
    rd_add_i = {5'd7, 5'd7};
    #1;
    check("r7_busy_c1", rd_busy_o, 64'h3);
    check("r7_dat_c1",  rd_dat_o,  64'h0);
    tick();
    tick();
    write_en_i = 1'b1; w_add_i = 5'd7; w_dat_i = 32'hA5A5A5A5;
    #1;
`ifdef REGFILE_BYPASS_EN
    check("r7_dat_c3",  rd_dat_o,  64'hA5A5A5A5_A5A5A5A5);
    check("r7_busy_c3", rd_busy_o, 64'h0);
`else
    check("r7_dat_c3",  rd_dat_o,  64'h0);
    check("r7_busy_c3", rd_busy_o, 64'h3);
`endif
    tick();
    write_en_i = 1'b0;
    #1;
    check("r7_dat_c4",      rd_dat_o,   64'hA5A5A5A5_A5A5A5A5);
    check("r7_busy_c4",     rd_busy_o,  64'h0);
    check("r7_busy_vec_c4", busy_vec_o, 64'h0);

    // 5: set/clear collision on r9; port0 reads r9, port1 reads r5
    sb_set_en_i = 1'b1; sb_set_add_i = 5'd9;
    tick();
    write_en_i = 1'b1; w_add_i = 5'd9; w_dat_i = 32'h00000001;
    rd_add_i = {5'd5, 5'd9};
    #1;
`ifdef REGFILE_BYPASS_EN
    check("r9_coll_dat", rd_dat_o, 64'h12345678_00000001);
`else
    check("r9_coll_dat", rd_dat_o, 64'h12345678_00000000);
`endif
    check("r9_coll_busy", rd_busy_o, 64'h1);
    tick();
    write_en_i = 1'b0; sb_set_en_i = 1'b0;
    #1;
    check("r9_after_dat",      rd_dat_o,   64'h12345678_00000001);
    check("r9_after_busy_vec", busy_vec_o, 64'h0000_0200);
    check("r9_after_rd_busy",  rd_busy_o,  64'h1);
    write_en_i = 1'b1; w_add_i = 5'd9; w_dat_i = 32'h00000002;
    tick();
    write_en_i = 1'b0;
    #1;
    check("r9_release_vec", busy_vec_o, 64'h0);
    check("r9_release_dat", rd_dat_o,   64'h12345678_00000002);

    // 6: swept configuration, r0 is the zero register
    for (int i = 0; i < 8; i++) begin
      s_write_en = 1'b1;
      s_w_add    = 3'(i);
      s_w_dat    = (i == 0) ? 16'hFFFF : 16'(i * 16'h1111);
      tick();
    end
    s_write_en = 1'b0;
    s_rd_add = {3'd7, 3'd4, 3'd2, 3'd0};
    #1;
    check("sw_rd_a",   s_rd_dat,  64'h7777_4444_2222_0000);
    check("sw_busy_a", s_rd_busy, 64'h0);
    s_rd_add = {3'd6, 3'd5, 3'd3, 3'd1};
    #1;
    check("sw_rd_b", s_rd_dat, 64'h6666_5555_3333_1111);
    s_sb_set_en = 1'b1; s_sb_set_add = 3'd0;
    tick();
    check("sw_r0_never_busy", s_busy_vec, 64'h0);
    s_sb_set_add = 3'd6;
    tick();
    s_sb_set_en = 1'b0;
    s_rd_add = {3'd6, 3'd6, 3'd0, 3'd1};
    #1;
    check("sw_r6_busy_vec", s_busy_vec, 64'h40);
    check("sw_r6_rd_busy",  s_rd_busy,  64'hC);
    s_write_en = 1'b1; s_w_add = 3'd6; s_w_dat = 16'hABCD;
    #1;
`ifdef REGFILE_BYPASS_EN
    check("sw_r6_wcycle_dat",  s_rd_dat,  64'hABCD_ABCD_0000_1111);
    check("sw_r6_wcycle_busy", s_rd_busy, 64'h0);
`else
    check("sw_r6_wcycle_dat",  s_rd_dat,  64'h6666_6666_0000_1111);
    check("sw_r6_wcycle_busy", s_rd_busy, 64'hC);
`endif
    tick();
    s_write_en = 1'b0;
    #1;
    check("sw_r6_after_dat", s_rd_dat,   64'hABCD_ABCD_0000_1111);
    check("sw_r6_after_vec", s_busy_vec, 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
